fpm_norm_round: RTL and testbench

FPM_NORM_ROUND -- requirements
Module: fpm_norm_round

---
 rtl/fpm_pkg.sv | 45 ++++
 rtl/fpm_round.sv | 49 ++++
 rtl/fpm_norm_round.sv | 96 +++++++++
 tb/tb_fpm_norm_round.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared constants, the S1 normalized-product record, and the S1 normalize helper
// for the single-precision multiplier back end.
package fpm_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 23;
    localparam int PROD_W   = 48;
    localparam int SIG_W    = MANT_W + 1;
    localparam int EXP_W    = 10;

    localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX);

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [SIG_W-1:0]        sig;
        logic                    guard;
        logic                    sticky;
        logic                    zero;
    } s1_t;

    // A 1.m x 1.m product lies in [1,4), so the leading one is at bit 47 or 46.
    function automatic s1_t normalize(input logic                    sign,
                                      input logic signed [EXP_W-1:0] exp,
                                      input logic [PROD_W-1:0]       mant,
                                      input logic                    zero);
        s1_t r;
        r.sign = sign;
        r.zero = zero;
        if (mant[PROD_W-1]) begin
            r.sig    = mant[47:24];
            r.guard  = mant[23];
            r.sticky = |mant[22:0];
            r.exp    = exp + 10'sd1;
        end else begin
            r.sig    = mant[46:23];
            r.guard  = mant[22];
            r.sticky = |mant[21:0];
            r.exp    = exp;
        end
        return r;
    endfunction

endpackage

// File: rtl/fpm_round.sv
// Combinational round-to-nearest-even, range check and IEEE-754 single packing
// of a normalized product.
module fpm_round
    import fpm_pkg::*;
#(
    parameter int FLUSH_SUBNORM = 1
) (
    input  s1_t         s1_i,
    output logic [31:0] p_o,
    output logic        ovf_o,
    output logic        unf_o
);

    localparam bit FLUSH = (FLUSH_SUBNORM != 0);

    logic                    inc;
    logic                    carry;
    logic [SIG_W:0]          sum;
    logic [MANT_W-1:0]       frac;
    logic signed [EXP_W-1:0] exp_r;

    always_comb begin
        inc   = s1_i.guard && (s1_i.sticky || s1_i.sig[0]);
        sum   = {1'b0, s1_i.sig} + {{SIG_W{1'b0}}, inc};
        // An all-ones significand rolls over to 10.000..., i.e. 1.0 at the next exponent.
        carry = sum[SIG_W] && !sum[SIG_W-1];
        if (carry) begin
            frac  = '0;
            exp_r = s1_i.exp + 10'sd1;
        end else begin
            frac  = sum[MANT_W-1:0];
            exp_r = s1_i.exp;
        end

        p_o   = {s1_i.sign, exp_r[7:0], frac};
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (s1_i.zero) begin
            p_o = {s1_i.sign, 31'b0};
        end else if (exp_r >= EXP_MAX_S) begin
            p_o   = {s1_i.sign, 8'hFF, 23'b0};
            ovf_o = 1'b1;
        end else if (FLUSH && (exp_r <= 10'sd0)) begin
            p_o   = {s1_i.sign, 31'b0};
            unf_o = 1'b1;
        end
    end

endmodule

// File: rtl/fpm_norm_round.sv
// Two-stage normalize / round-and-pack back end of a single-precision multiplier
// with valid/ready handshakes on both sides.
module fpm_norm_round
    import fpm_pkg::*;
#(
    parameter int FLUSH_SUBNORM = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [PROD_W-1:0]       in_mant,
    input  logic                    in_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_p,
    output logic                    out_ovf,
    output logic                    out_unf
);

    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    s1_t         s1_q, s1_d;
    logic        s1_load, s2_load;
    logic [31:0] p_rnd, out_p_q;
    logic        ovf_rnd, unf_rnd, ovf_q, unf_q;

    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        s1_d = normalize(in_sign, in_exp, in_mant, in_zero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // S1: normalized product; payload needs no reset because s1_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_q <= s1_d;
        end
    end

    fpm_round #(
        .FLUSH_SUBNORM(FLUSH_SUBNORM)
    ) u_round (
        .s1_i (s1_q),
        .p_o  (p_rnd),
        .ovf_o(ovf_rnd),
        .unf_o(unf_rnd)
    );

    // S2: packed result register, cleared in reset so the outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (s2_load) begin
            out_p_q <= p_rnd;
            ovf_q   <= ovf_rnd;
            unf_q   <= unf_rnd;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_p     = out_p_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

endmodule

// File: tb/tb_fpm_norm_round.sv
// Self-checking bench for fpm_norm_round: directed cases, backpressure, reset
// mid-flight and a randomized stream against a value-level reference model.
module tb_fpm_norm_round;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sign = 1'b0;
    logic signed [9:0]  in_exp = '0;
    logic [47:0]        in_mant = '0;
    logic               in_zero = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_p;
    logic               out_ovf;
    logic               out_unf;

    logic [33:0] exp_q[$];
    int          n_asserts = 0;
    int          n_fail = 0;
    logic        held_vld = 1'b0;
    logic [33:0] held = '0;
    logic        last_acc = 1'b0;

    always #5 clk = ~clk;

    fpm_norm_round #(.FLUSH_SUBNORM(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sign  (in_sign),
        .in_exp   (in_exp),
        .in_mant  (in_mant),
        .in_zero  (in_zero),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p),
        .out_ovf  (out_ovf),
        .out_unf  (out_unf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference: value = mant * 2^(exp-127-46); renormalize to 24 bits, RNE, range-check.
    function automatic logic [33:0] ref_model(input logic s, input logic signed [9:0] ex,
                                              input logic [47:0] m, input logic z);
        int pos, e, sh;
        longint unsigned q, r, half;
        if (z) return {2'b00, s, 31'b0};
        pos = 0;
        for (int i = 0; i < 48; i++) if (m[i]) pos = i;
        e    = int'(ex) + pos - 46;
        sh   = pos - 23;
        q    = 64'(m) >> sh;
        r    = 64'(m) - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'b0};
        if (e <= 0) return {2'b01, s, 31'b0};
        return {2'b00, s, 8'(e), q[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_asserts++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic drive(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                         input logic z);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_zero  = z;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("result", 64'({out_ovf, out_unf, out_p}), 64'(exp_q.pop_front()));
        end
        if (held_vld && out_valid) chk("hold_stable", 64'({out_ovf, out_unf, out_p}), 64'(held));
        held_vld = out_valid && !out_ready;
        held     = {out_ovf, out_unf, out_p};
        last_acc = in_valid && in_ready;
        if (last_acc) exp_q.push_back(ref_model(in_sign, in_exp, in_mant, in_zero));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                        input logic z);
        drive(s, e, m, z);
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_accepted", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    // Single product through an otherwise idle pipe, checked against a fixed value.
    task automatic run1(input string tag, input logic s, input logic signed [9:0] e,
                        input logic [47:0] m, input logic z, input logic [33:0] want);
        send(s, e, m, z);
        tick();
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk(tag, 64'({out_ovf, out_unf, out_p}), 64'(want));
        tick();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [23:0] a, b;
        logic [47:0] m;
        logic [47:0] bp_m[4];

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outs", 64'({out_ovf, out_unf, out_p}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(out_valid), 64'd0);

        // 5.5 x 15.25 with explicit two-cycle latency
        drive(1'b0, 10'sd132, 48'hA7C000000000, 1'b0);
        tick();
        chk("lat_accept", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_cycle2", 64'(out_valid), 64'd1);
        chk("mul_5p5x15p25", 64'({out_ovf, out_unf, out_p}), 64'({2'b00, 32'h42A7C000}));
        tick();

        run1("mul_10x1", 1'b0, 10'sd130, 48'h500000000000, 1'b0, {2'b00, 32'h41200000});
        run1("mul_10x0", 1'b0, 10'sd130, 48'h000000000000, 1'b1, {2'b00, 32'h00000000});
        run1("rne_tie_even", 1'b0, 10'sd127, 48'h400000400000, 1'b0, {2'b00, 32'h3F800000});
        run1("rne_tie_odd", 1'b0, 10'sd127, 48'h400000C00000, 1'b0, {2'b00, 32'h3F800002});
        run1("rne_carry", 1'b0, 10'sd127, 48'h7FFFFFC00000, 1'b0, {2'b00, 32'h40000000});
        run1("overflow", 1'b0, 10'sd260, 48'h400000000000, 1'b0, {2'b10, 32'h7F800000});
        run1("underflow", 1'b1, -10'sd5, 48'h400000000000, 1'b0, {2'b01, 32'h80000000});
        run1("zero_beats_ovf", 1'b1, 10'sd300, 48'h400000000000, 1'b1, {2'b00, 32'h80000000});
        drain();

        // Backpressure: two slots fill, then input is refused while the output is held
        for (int k = 0; k < 4; k++) bp_m[k] = 48'h400000000000 | (48'(k + 1) << 30);
        out_ready = 1'b0;
        drive(1'b0, 10'sd127, bp_m[0], 1'b0);
        tick();
        chk("bp_acc0", 64'(last_acc), 64'd1);
        drive(1'b1, 10'sd128, bp_m[1], 1'b0);
        tick();
        chk("bp_acc1", 64'(last_acc), 64'd1);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 10'sd129, bp_m[2], 1'b0);
        tick();
        chk("bp_refused_a", 64'(last_acc), 64'd0);
        tick();
        chk("bp_refused_b", 64'(last_acc), 64'd0);
        out_ready = 1'b1;
        send(1'b0, 10'sd129, bp_m[2], 1'b0);
        send(1'b1, 10'sd130, bp_m[3], 1'b0);
        drain();

        // Reset with two products in flight
        out_ready = 1'b0;
        send(1'b0, 10'sd140, 48'h600000000000, 1'b0);
        send(1'b0, 10'sd141, 48'h700000000000, 1'b0);
        chk("mf_full", 64'({out_valid, in_ready}), 64'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mf_out_valid_now", 64'(out_valid), 64'd0);
        chk("mf_in_ready_now", 64'(in_ready), 64'd1);
        chk("mf_out_p_now", 64'(out_p), 64'd0);
        exp_q.delete();
        held_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mf_no_stale", 64'(out_valid), 64'd0);
        end
        run1("mf_recover", 1'b0, 10'sd130, 48'h500000000000, 1'b0, {2'b00, 32'h41200000});

        // Randomized stream with random backpressure; inputs held while refused
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    a = {1'b1, 23'($urandom)};
                    b = {1'b1, 23'($urandom)};
                    m = 48'(a) * 48'(b);
                    if ($urandom_range(0, 7) == 0) m = {m[47:23], 1'b1, 22'b0};
                    drive(1'($urandom), 10'($urandom_range(0, 320) - 20), m,
                          ($urandom_range(0, 15) == 0));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
